// File: rtl/wb_pkg.sv
// Shared widths and the queued write-back entry type for the write-back arbiter.
package wb_pkg;
  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NREG = 2 ** AW;

  typedef struct packed {
    logic            valid;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] wd;
  } wb_entry_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// Write-back bus: ALU request, multi-cycle handshake, RF write port and queue status.
interface wb_arbiter_if;
  import wb_pkg::*;

  logic            alu_we;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_wd;
  logic            lsu_valid;
  logic            lsu_ready;
  logic [AW-1:0]   lsu_rd;
  logic [XLEN-1:0] lsu_wd;
  logic            rf_we3;
  logic [AW-1:0]   rf_a3;
  logic [XLEN-1:0] rf_wd3;
  logic [NREG-1:0] pend_mask;
  logic            q_full;
  logic            q_empty;

  modport master (
    output alu_we, alu_rd, alu_wd, lsu_valid, lsu_rd, lsu_wd,
    input  lsu_ready, rf_we3, rf_a3, rf_wd3, pend_mask, q_full, q_empty
  );

  modport slave (
    input  alu_we, alu_rd, alu_wd, lsu_valid, lsu_rd, lsu_wd,
    output lsu_ready, rf_we3, rf_a3, rf_wd3, pend_mask, q_full, q_empty
  );
endinterface

// File: rtl/wb_queue.sv
// Circular buffer of write-back entries with rd-based squash of queued writes.
module wb_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  wb_entry_t                push_entry,
  input  logic                     pop,
  input  logic                     squash_en,
  input  logic [AW-1:0]            squash_rd,
  output wb_entry_t                head,
  output logic                     full,
  output logic                     empty,
  output logic [DEPTH-1:0]         ent_valid,
  output logic [DEPTH-1:0][AW-1:0] ent_rd
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    for (int i = 0; i < DEPTH; i++) begin
      if (squash_en && mem_q[i].rd == squash_rd) mem_d[i].valid = 1'b0;
    end
    // Popped slots drop their valid bit so the pending mask only sees live entries.
    if (pop)  mem_d[rd_ptr_q].valid = 1'b0;
    if (push) mem_d[wr_ptr_q]       = push_entry;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    head  = mem_q[rd_ptr_q];
    full  = (cnt_q == CW'(DEPTH));
    empty = (cnt_q == '0);
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid[i] = mem_q[i].valid;
      ent_rd[i]    = mem_q[i].rd;
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// Merges single-cycle ALU writes and queued multi-cycle results onto one RF write port.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  wb_arbiter_if.slave  bus
);
  wb_entry_t                head;
  wb_entry_t                push_entry;
  logic                     full, empty;
  logic                     push, pop, alu_win;
  logic [DEPTH-1:0]         ent_valid;
  logic [DEPTH-1:0][AW-1:0] ent_rd;

  assign alu_win = bus.alu_we && (bus.alu_rd != '0);
  // x0 results complete the handshake but are never stored.
  assign push    = bus.lsu_valid && !full && (bus.lsu_rd != '0);
  // A squashed head leaves even when the ALU owns the port.
  assign pop     = !empty && (!head.valid || !alu_win);

  always_comb begin
    push_entry.valid = !(alu_win && bus.alu_rd == bus.lsu_rd);
    push_entry.rd    = bus.lsu_rd;
    push_entry.wd    = bus.lsu_wd;
  end

  wb_queue #(.DEPTH(DEPTH)) u_queue (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .squash_en  (alu_win),
    .squash_rd  (bus.alu_rd),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .ent_valid  (ent_valid),
    .ent_rd     (ent_rd)
  );

  always_comb begin
    bus.rf_we3 = 1'b0;
    bus.rf_a3  = '0;
    bus.rf_wd3 = '0;
    if (reset_n) begin
      if (alu_win) begin
        bus.rf_we3 = 1'b1;
        bus.rf_a3  = bus.alu_rd;
        bus.rf_wd3 = bus.alu_wd;
      end else if (!empty && head.valid) begin
        bus.rf_we3 = 1'b1;
        bus.rf_a3  = head.rd;
        bus.rf_wd3 = head.wd;
      end
    end
  end

  always_comb begin
    bus.pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i]) bus.pend_mask[ent_rd[i]] = 1'b1;
    end
    bus.pend_mask[0] = 1'b0;
  end

  assign bus.lsu_ready = reset_n && !full;
  assign bus.q_full    = reset_n && full;
  assign bus.q_empty   = !reset_n || empty;
endmodule
